pio_stream_bridge: RTL
======================

Name: pio_stream_bridge

Overview:
- Converts the CPU-side PIO byte interface (data_out, write_en, start_bit, reset_cnt) into a framed valid/ready word stream for the convolution filter datapath.
- Packs LANES bytes per output word and buffers them in a FIFO of FIFO_DEPTH entries.
- Frames transfers to a programmable word count and reports level, overflow and completion back to the CPU's input PIOs.
- Supersedes the fixed 8-bit single-strobe handoff with width, depth and framing control.

Parameters:
- DATA_W, 8, width of one PIO data beat.
- LANES, 1, beats packed per output word (1..4).
- FIFO_DEPTH, 16, FIFO entries; power of two, >=2.
- CNT_W, 16, width of frame length and word counter.

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  synchronous reset, active-high
- pio_data  in  DATA_W  byte from CPU data_out PIO
- pio_write_en  in  1  level from PIO; each rising edge = one beat
- pio_start  in  1  level; rising edge arms a frame
- pio_reset_cnt  in  1  level; while high, flush and clear
- frame_len  in  CNT_W  words per frame, sampled on start edge
- m_data  out  DATA_W*LANES  output word; first beat in LSBs
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts
- m_last  out  1  marks last word of frame
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky: a word was dropped on full FIFO
- busy  out  1  high in ARMED or DRAIN
- frame_done  out  1  one-cycle pulse at frame completion
- word_cnt  out  CNT_W  words pushed in current frame

Behaviour:
- Reset (reset_reset=1) values:
  - all outputs 0; fifo_level=0
  - state=IDLE
  - edge registers = 0, so a level already high after reset counts as an edge
- Edge detect: we_q/st_q register the previous sample. Write edge = pio_write_en & ~we_q; start edge likewise.
- Priority order: reset_reset > pio_reset_cnt > start edge > write edge > pop.
- pio_reset_cnt=1, acting as a synchronous clear:
  - empties the FIFO, zeroes word_cnt, lane index and pack register
  - clears overflow; state -> IDLE
  - write and start edges in that cycle are discarded
- States:
  - IDLE: write edges ignored. A start edge with frame_len!=0 latches len_r=frame_len, zeroes word_cnt and lane_idx, and goes to ARMED. A start edge with frame_len==0 is ignored.
  - ARMED: on each write edge, pio_data goes into lane lane_idx. When lane_idx==LANES-1, the packed word (combinational with the current beat) is pushed in the same clock, word_cnt increments, and lane_idx wraps to 0. The push where word_cnt==len_r-1 carries last=1 and moves to DRAIN. Start edges are ignored.
  - DRAIN: write edges ignored. When the FIFO is empty and no pop is in progress, go to DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE.
- FIFO:
  - width DATA_W*LANES+1; the extra bit is last, which drives m_last.
  - show-ahead: m_valid=~empty, and m_data/m_last present the head entry.
  - pop when m_valid&m_ready.
- Latency: a write edge that completes a word in cycle n gives m_valid=1 in cycle n+1, if the FIFO was empty.
- Full FIFO:
  - push with a simultaneous pop is accepted, and level is unchanged.
  - push without a pop drops the word and sets overflow. word_cnt still increments, and the last flag is lost only if the dropped word was last (state still goes to DRAIN).
- Simultaneous push and pop on an empty FIFO: no pop occurs (m_valid=0); the push is accepted.
- m_valid held with m_ready=0: m_data and m_last stay stable.
- fifo_level equals writes minus reads; the range 0..FIFO_DEPTH is exact.
- busy = (state==ARMED) | (state==DRAIN).

Decomposition:
- Package pio_stream_pkg:
  - state enum {IDLE, ARMED, DRAIN, DONE}
  - clog2 function
  - MAX_LANES=4 constant
- Sub-module sync_fifo:
  - parameters WIDTH and DEPTH
  - ports: push, pop, wdata, rdata, empty, full, level
  - synchronous clear input driven by reset_reset|pio_reset_cnt

Test Plan:
- LANES=1, frame_len=3, three write edges with 0x11, 0x22, 0x33, m_ready=1 -> m_data 0x11, 0x22, 0x33 on consecutive valid cycles, each 1 cycle after its edge; m_last only on 0x33; frame_done pulses once; busy then 0.
- LANES=4, frame_len=2, eight beats 0x01..0x08 -> words 0x04030201, then 0x08070605 with m_last=1; beats 1-3 produce no m_valid.
- FIFO_DEPTH=4, LANES=1, m_ready=0, six beats, frame_len=8 -> fifo_level=4, overflow=1 after the 5th beat, word_cnt=6. Then m_ready=1 -> exactly 4 words, 0x01..0x04.
- Write edges in IDLE, and a start edge with frame_len=0 -> no push; state remains IDLE; busy=0.
- pio_reset_cnt pulsed mid-frame with 2 words queued and a partial pack -> next cycle m_valid=0, fifo_level=0, word_cnt=0, overflow=0, state IDLE. A new start edge then yields a correct fresh frame.
- FIFO full with m_ready=1 and a completing write edge in the same cycle -> word accepted, fifo_level unchanged, overflow stays 0.

Source files
------------

// File: rtl/pio_stream_bridge_pkg.sv
// Shared types and helpers for the PIO-to-stream bridge.
package pio_stream_pkg;

    // Widest word the packer supports, in beats.
    localparam int MAX_LANES = 4;

    // Frame sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pio_stream_bridge_if.sv
// Valid/ready word stream carrying packed PIO beats plus an end-of-frame flag.
interface pio_stream_bridge_if #(
    parameter int W = 8
);
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/pio_stream_bridge_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on rdata whenever
// the FIFO is non-empty, so a word pushed in one cycle is presented the next.
module sync_fifo
    import pio_stream_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [clog2(DEPTH):0]  level
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LW'(DEPTH));
    assign level   = level_reg;
    assign rdata   = mem[rd_ptr_reg];

    // A pop on an empty FIFO is meaningless; a push into a full FIFO only
    // fits if a pop frees a slot in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Storage write; contents need no reset because level gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/pio_stream_bridge.sv
// Turns level-signalled PIO beats into framed, packed valid/ready words.
// Each rising edge of pio_write_en is one beat; LANES beats form a word,
// first beat in the LSBs. A rising edge of pio_start arms a frame of
// frame_len words; the last word carries m_last, and once the FIFO has
// drained the bridge pulses frame_done.
module pio_stream_bridge
    import pio_stream_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int LANES      = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic [DATA_W-1:0]           pio_data,
    input  logic                        pio_write_en,
    input  logic                        pio_start,
    input  logic                        pio_reset_cnt,
    input  logic [CNT_W-1:0]            frame_len,
    pio_stream_bridge_if.master         m,
    output logic [clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                        overflow,
    output logic                        busy,
    output logic                        frame_done,
    output logic [CNT_W-1:0]            word_cnt
);

    localparam int WORD_W = DATA_W * LANES;
    localparam int LANE_W = clog2(MAX_LANES);

    state_t            state_reg;
    state_t            state_next;
    logic              we_q;
    logic              st_q;
    logic [CNT_W-1:0]  len_reg;
    logic [CNT_W-1:0]  len_next;
    logic [CNT_W-1:0]  word_cnt_reg;
    logic [CNT_W-1:0]  word_cnt_next;
    logic [LANE_W-1:0] lane_reg;
    logic [LANE_W-1:0] lane_next;
    logic [WORD_W-1:0] pack_reg;
    logic [WORD_W-1:0] pack_next;
    logic              overflow_reg;
    logic              overflow_next;

    logic              wr_edge;
    logic              st_edge;
    logic              fifo_clear;
    logic              push;
    logic              push_last;
    logic              pop;
    logic [WORD_W-1:0] beat_word;
    logic [WORD_W:0]   fifo_rdata;
    logic              fifo_empty;
    logic              fifo_full;

    assign wr_edge    = pio_write_en & ~we_q;
    assign st_edge    = pio_start & ~st_q;
    assign fifo_clear = reset_reset | pio_reset_cnt;
    assign pop        = ~fifo_empty & m.m_ready;

    // The current beat is merged into its lane combinationally so that the
    // completing beat can be pushed in the same clock it arrives.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign beat_word[gi*DATA_W +: DATA_W] =
                (lane_reg == LANE_W'(gi)) ? pio_data : pack_reg[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Frame sequencing, packing and overflow detection.
    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        word_cnt_next = word_cnt_reg;
        lane_next     = lane_reg;
        pack_next     = pack_reg;
        overflow_next = overflow_reg;
        push          = 1'b0;
        push_last     = 1'b0;

        if (pio_reset_cnt) begin
            // Flush wins over any edge seen in the same cycle.
            state_next    = IDLE;
            word_cnt_next = '0;
            lane_next     = '0;
            pack_next     = '0;
            overflow_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (st_edge && (frame_len != '0)) begin
                        len_next      = frame_len;
                        word_cnt_next = '0;
                        lane_next     = '0;
                        state_next    = ARMED;
                    end
                end
                ARMED: begin
                    if (wr_edge) begin
                        pack_next = beat_word;
                        if (lane_reg == LANE_W'(LANES - 1)) begin
                            push          = 1'b1;
                            word_cnt_next = word_cnt_reg + CNT_W'(1);
                            lane_next     = '0;
                            if (word_cnt_reg == len_reg - CNT_W'(1)) begin
                                push_last  = 1'b1;
                                state_next = DRAIN;
                            end
                        end else begin
                            lane_next = lane_reg + LANE_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    // An empty FIFO cannot have a pop in flight.
                    if (fifo_empty) begin
                        state_next = DONE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            // A word counts toward the frame even when it has nowhere to go.
            if (push && fifo_full && !pop) begin
                overflow_next = 1'b1;
            end
        end
    end

    // State and edge-history registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_reg    <= IDLE;
            we_q         <= 1'b0;
            st_q         <= 1'b0;
            len_reg      <= '0;
            word_cnt_reg <= '0;
            lane_reg     <= '0;
            pack_reg     <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            we_q         <= pio_write_en;
            st_q         <= pio_start;
            len_reg      <= len_next;
            word_cnt_reg <= word_cnt_next;
            lane_reg     <= lane_next;
            pack_reg     <= pack_next;
            overflow_reg <= overflow_next;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .clear (fifo_clear),
        .push  (push),
        .pop   (pop),
        .wdata ({push_last, beat_word}),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .level (fifo_level)
    );

    // Empty-FIFO data is forced to zero so stale storage never shows.
    assign m.m_valid  = ~fifo_empty;
    assign m.m_data   = fifo_empty ? '0 : fifo_rdata[WORD_W-1:0];
    assign m.m_last   = ~fifo_empty & fifo_rdata[WORD_W];

    assign overflow   = overflow_reg;
    assign busy       = (state_reg == ARMED) | (state_reg == DRAIN);
    assign frame_done = (state_reg == DONE);
    assign word_cnt   = word_cnt_reg;

endmodule
